// File: rtl/medium_matrix_reader_pkg.sv
// Shared types and sizing helpers for the medium matrix reader.
// FILL/DRAIN encoding, default tile geometry and index-width helper.
package medium_matrix_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int DEF_DIM    = 4;
    localparam int DEF_DATA_W = 4;

    function automatic int idx_w(input int dim);
        return (dim < 2) ? 1 : $clog2(dim);
    endfunction

endpackage

// File: rtl/medium_matrix_reader_if.sv
// Element stream bundle for the matrix reader: input side and output side valid/ready.
// slave = reader, master = tile producer plus column consumer.
interface medium_matrix_reader_if #(
    parameter int DATA_W = medium_matrix_pkg::DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/medium_matrix_reader_idx_counter.sv
// Row/col pair counter wrapping at DIM-1; ROW_FAST picks the fast index.
// LOOKAHEAD=1 presents the post-increment pair so callers can prefetch; clear wins over enable.
module medium_matrix_idx_counter
    import medium_matrix_pkg::*;
#(
    parameter int DIM       = DEF_DIM,
    parameter bit ROW_FAST  = 1'b0,
    parameter bit LOOKAHEAD = 1'b0,
    localparam int IW       = idx_w(DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_clr,
    output logic [IW-1:0] o_row,
    output logic [IW-1:0] o_col,
    output logic          o_last
);
    localparam logic [IW-1:0] MAX = IW'(DIM - 1);

    logic [IW-1:0] r_row;
    logic [IW-1:0] r_col;
    logic [IW-1:0] w_fast;
    logic [IW-1:0] w_slow;
    logic [IW-1:0] w_fast_nxt;
    logic [IW-1:0] w_slow_nxt;
    logic [IW-1:0] w_row_nxt;
    logic [IW-1:0] w_col_nxt;

    assign w_fast = ROW_FAST ? r_row : r_col;
    assign w_slow = ROW_FAST ? r_col : r_row;

    always_comb begin
        w_fast_nxt = (w_fast == MAX) ? '0 : w_fast + 1'b1;
        w_slow_nxt = w_slow;
        if (w_fast == MAX) begin
            w_slow_nxt = (w_slow == MAX) ? '0 : w_slow + 1'b1;
        end
    end

    assign w_row_nxt = ROW_FAST ? w_fast_nxt : w_slow_nxt;
    assign w_col_nxt = ROW_FAST ? w_slow_nxt : w_fast_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    assign o_row  = LOOKAHEAD ? w_row_nxt : r_row;
    assign o_col  = LOOKAHEAD ? w_col_nxt : r_col;
    assign o_last = (o_row == MAX) && (o_col == MAX);
endmodule

// File: rtl/medium_matrix_reader.sv
// Buffers one DIM x DIM row-major tile, then drains it; first output one cycle after last input.
// Output holds under out_ready=0; MEDIUM_MATRIX_READER_TRANSPOSE_EN selects column-major drain.
module medium_matrix_reader
    import medium_matrix_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIM    = DEF_DIM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    medium_matrix_reader_if.slave  bus,
    output logic                   busy,
    output logic [7:0]             tile_cnt
);
    localparam int IW = idx_w(DIM);
    localparam int AW = idx_w(DIM * DIM);
`ifdef MEDIUM_MATRIX_READER_TRANSPOSE_EN
    localparam bit RD_ROW_FAST = 1'b1;
`else
    localparam bit RD_ROW_FAST = 1'b0;
`endif

    state_t            r_state;
    state_t            w_nxt_state;
    logic [DATA_W-1:0] r_mem [DIM*DIM];

    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic [DATA_W-1:0] r_out_data;
    logic [7:0]        r_tile_cnt;

    logic              w_nxt_out_valid;
    logic              w_nxt_out_last;
    logic [DATA_W-1:0] w_nxt_out_data;
    logic [7:0]        w_nxt_tile_cnt;

    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_fill_done;
    logic [IW-1:0]     w_wr_row;
    logic [IW-1:0]     w_wr_col;
    logic              w_wr_last;
    logic [IW-1:0]     w_rd_nrow;
    logic [IW-1:0]     w_rd_ncol;
    logic              w_rd_nlast;

    function automatic logic [AW-1:0] flat_addr(input logic [IW-1:0] row, input logic [IW-1:0] col);
        return AW'(row) * AW'(DIM) + AW'(col);
    endfunction

    assign w_in_hs  = bus.in_valid && r_in_ready;
    assign w_out_hs = r_out_valid && bus.out_ready;

    medium_matrix_idx_counter #(.DIM(DIM), .ROW_FAST(1'b0), .LOOKAHEAD(1'b0)) u_wr_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_in_hs),
        .i_clr  (w_fill_done),
        .o_row  (w_wr_row),
        .o_col  (w_wr_col),
        .o_last (w_wr_last)
    );

    // Read side looks one element ahead so out_data can reload on the accepting edge.
    medium_matrix_idx_counter #(.DIM(DIM), .ROW_FAST(RD_ROW_FAST), .LOOKAHEAD(1'b1)) u_rd_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_out_hs),
        .i_clr  (w_fill_done),
        .o_row  (w_rd_nrow),
        .o_col  (w_rd_ncol),
        .o_last (w_rd_nlast)
    );

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_mem[flat_addr(w_wr_row, w_wr_col)] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_out_valid = r_out_valid;
        w_nxt_out_last  = r_out_last;
        w_nxt_out_data  = r_out_data;
        w_nxt_tile_cnt  = r_tile_cnt;
        w_fill_done     = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_in_hs && w_wr_last) begin
                    w_nxt_state     = DRAIN;
                    w_nxt_out_valid = 1'b1;
                    w_nxt_out_last  = 1'b0;
                    w_nxt_out_data  = r_mem[0];
                    w_fill_done     = 1'b1;
                end
            end
            DRAIN: begin
                if (w_out_hs) begin
                    if (r_out_last) begin
                        w_nxt_state     = FILL;
                        w_nxt_out_valid = 1'b0;
                        w_nxt_out_last  = 1'b0;
                        w_nxt_tile_cnt  = r_tile_cnt + 8'd1;
                    end else begin
                        w_nxt_out_data  = r_mem[flat_addr(w_rd_nrow, w_rd_ncol)];
                        w_nxt_out_last  = w_rd_nlast;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_tile_cnt  <= 8'd0;
        end else begin
            r_in_ready  <= (w_nxt_state == FILL);
            r_out_valid <= w_nxt_out_valid;
            r_out_last  <= w_nxt_out_last;
            r_out_data  <= w_nxt_out_data;
            r_busy      <= (w_nxt_state == DRAIN);
            r_tile_cnt  <= w_nxt_tile_cnt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_data;
    assign busy          = r_busy;
    assign tile_cnt      = r_tile_cnt;
endmodule
